poly_add_seq: RTL and testbench
===============================

Name: poly_add_seq

Overview:
- Sequences one shared 12-bit carry-look-ahead adder to compute coefficient-wise modular polynomial sums for Kyber encapsulation.
- Two-operand mode computes r = a + b mod q, used for u = A^T r + e1.
- Three-operand mode computes v = y + msg_poly + e2 mod q.
- Sits between the coefficient RAMs (1-cycle read latency) and the result RAM/compress stage; a single adder instance is time-shared between both additions.

Parameters:
- DATA_WID, 12, coefficient width.
- N_COEF, 256, coefficients per polynomial.
- ADDR_WID, 8, coefficient address width (log2 N_COEF).
- Q, 3329, Kyber modulus.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- three_op  input  1  mode select, captured on accepted start; 1 = a+b+c, 0 = a+b.
- rd_en  output  1  read strobe to operand RAMs.
- rd_addr  output  ADDR_WID  operand coefficient index.
- a_data  input  DATA_WID  operand A; valid the cycle after rd_en.
- b_data  input  DATA_WID  operand B; valid the cycle after rd_en.
- c_data  input  DATA_WID  operand C; valid the cycle after rd_en; ignored when three_op=0.
- wr_en  output  1  result write request.
- wr_addr  output  ADDR_WID  result index.
- wr_data  output  DATA_WID  reduced result in [0,Q-1].
- wr_ready  input  1  sink accepts the write on a cycle where wr_en=1.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last coefficient is written.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rd_en, wr_en, busy, done = 0; rd_addr, wr_addr, wr_data, index counter, tmp, captured mode = 0. Reset mid-operation abandons the polynomial; no further writes occur.
- FSM states: IDLE, RD, ADD1, ADD2, WR, FIN.
- IDLE: start=1 -> capture three_op, idx=0, busy=1, go to RD. start is ignored in every other state.
- RD: rd_en=1, rd_addr=idx for exactly one cycle -> ADD1.
- ADD1: operands valid. Adder computes s = a_data + b_data (13-bit, carry in MSB). Reduce: s >= Q ? s-Q : s. Register the 12-bit result into tmp. Go to ADD2 if three_op, else copy tmp to wr_data and go to WR.
- ADD2: adder computes tmp + c_data; same single conditional subtraction; register into wr_data -> WR.
- WR: wr_en=1, wr_addr=idx, wr_data stable. Stay in WR while wr_ready=0; outputs held. On wr_ready=1: if idx==N_COEF-1 go to FIN, else idx+1 and go to RD.
- FIN: done=1 for one cycle, busy=0 on exit -> IDLE. start in FIN is ignored.
- Adder: a single instance, input mux selecting (a_data, b_data) in ADD1 and (tmp, c_data) in ADD2. Carry-in is 0. The 13-bit sum feeds the reducer.
- Inputs in [0,Q-1] give exact mod-q results. Out-of-range inputs receive only one subtraction; no error flag is raised.
- Throughput with wr_ready held at 1: 3 cycles/coef (2-op), 4 cycles/coef (3-op). done is high in the cycle 3*N_COEF+1 (2-op) or 4*N_COEF+1 (3-op) clocks after the start-sampling edge.
- idx never wraps. The terminal check at N_COEF-1 ends the run, and idx returns to 0 only on the next accepted start.
- Mode change on three_op while busy has no effect.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with start=0 -> all outputs 0, no rd_en/wr_en pulses.
- 2-op mode, a=3000, b=500 at all indices, wr_ready=1 -> every wr_data=171, wr_addr 0..255 in order, done exactly 769 clocks after start edge, busy falls with done.
- 3-op mode, a=b=c=3328 -> every wr_data=3326. Also a=0, b=0, c=3328 -> 3328. Also a=1664, b=1665, c=0 -> 0 (exact-Q boundary). done at 4*256+1 clocks.
- Backpressure: wr_ready low for 5 cycles at idx=17 -> wr_en, wr_addr=17, wr_data held constant, no rd_en during the stall, completion delayed by exactly 5 cycles.
- start asserted while busy and in FIN -> ignored; only one done pulse. A second start after returning to IDLE runs a full new polynomial from idx 0.
- rst_n asserted mid-run at idx=100 in WR -> outputs zero immediately (asynchronously), no done pulse; a subsequent start restarts at idx 0.

Source files
------------

// File: rtl/poly_add_seq.sv
// rtl/poly_add_seq.sv - Sequenced modular polynomial adder (a+b or a+b+c mod Q) with one shared CLA
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, three_op     run request (IDLE only) and mode captured with it
//   rd_en, rd_addr      operand RAM read strobe/index (data returns next cycle)
//   a_data/b_data/c_data operand coefficients
//   wr_en, wr_addr, wr_data, wr_ready  result write handshake
//   busy, done          run in progress / one-cycle completion pulse

module poly_add_cla #(
    parameter int W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    localparam int NG = W / 4;

    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [W-1:0]  w_c;
    logic [NG:0]   w_gc;

    // 4-bit lookahead groups; group carries chain across groups.
    always_comb begin
        w_g  = i_a & i_b;
        w_p  = i_a ^ i_b;
        w_c  = '0;
        w_gc = '0;
        w_gc[0] = i_cin;
        for (int k = 0; k < NG; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_gc[k+1]  = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (&w_p[4*k +: 4] & w_gc[k]);
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[NG];
endmodule

module poly_add_seq #(
    parameter int DATA_WID = 12,
    parameter int N_COEF   = 256,
    parameter int ADDR_WID = 8,
    parameter int Q        = 3329
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                three_op,
    output logic                rd_en,
    output logic [ADDR_WID-1:0] rd_addr,
    input  logic [DATA_WID-1:0] a_data,
    input  logic [DATA_WID-1:0] b_data,
    input  logic [DATA_WID-1:0] c_data,
    output logic                wr_en,
    output logic [ADDR_WID-1:0] wr_addr,
    output logic [DATA_WID-1:0] wr_data,
    input  logic                wr_ready,
    output logic                busy,
    output logic                done
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_ADD1 = 3'd2,
        S_ADD2 = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [DATA_WID:0]   Q_EXT    = (DATA_WID+1)'(Q);
    localparam logic [ADDR_WID-1:0] LAST_IDX = ADDR_WID'(N_COEF - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_WID-1:0] r_idx;
    logic [DATA_WID-1:0] r_tmp;
    logic [DATA_WID-1:0] r_wr_data;
    logic                r_mode;
    logic                r_busy;
    logic                r_done;
    logic                w_rd_en;
    logic                w_wr_en;

    logic [DATA_WID-1:0] w_op_a;
    logic [DATA_WID-1:0] w_op_b;
    logic [DATA_WID-1:0] w_sum_lo;
    logic                w_cout;
    logic [DATA_WID:0]   w_sum;
    logic [DATA_WID:0]   w_diff;
    logic [DATA_WID-1:0] w_red;

    // Shared adder: second pass folds c into the partial sum held in r_tmp.
    assign w_op_a = (r_state == S_ADD2) ? r_tmp  : a_data;
    assign w_op_b = (r_state == S_ADD2) ? c_data : b_data;

    poly_add_cla #(.W(DATA_WID)) u_cla (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum_lo),
        .o_cout (w_cout)
    );

    // One conditional subtraction; exact only for operands already in [0,Q-1].
    assign w_sum  = {w_cout, w_sum_lo};
    assign w_diff = w_sum - Q_EXT;
    assign w_red  = (w_sum >= Q_EXT) ? w_diff[DATA_WID-1:0] : w_sum[DATA_WID-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_RD;
            S_RD: begin
                w_rd_en = 1'b1;
                w_next  = S_ADD1;
            end
            S_ADD1: w_next = r_mode ? S_ADD2 : S_WR;
            S_ADD2: w_next = S_WR;
            S_WR: begin
                w_wr_en = 1'b1;
                if (wr_ready) w_next = (r_idx == LAST_IDX) ? S_FIN : S_RD;
            end
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_tmp     <= '0;
            r_wr_data <= '0;
            r_mode    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= three_op;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_ADD1: begin
                    r_tmp <= w_red;
                    if (!r_mode) r_wr_data <= w_red;
                end
                S_ADD2: r_wr_data <= w_red;
                S_WR: begin
                    // idx holds at the last index; it is cleared only by the next start.
                    if (wr_ready && (r_idx != LAST_IDX)) r_idx <= r_idx + ADDR_WID'(1);
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rd_en   = w_rd_en;
    assign rd_addr = r_idx;
    assign wr_en   = w_wr_en;
    assign wr_addr = r_idx;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule

// File: tb/tb_poly_add_seq.sv
// tb/tb_poly_add_seq.sv - Directed table-driven bench for poly_add_seq
module tb_poly_add_seq;
    localparam int DW = 12;
    localparam int N  = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          three_op = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic [DW-1:0] c_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready = 1'b1;
    logic          busy;
    logic          done;

    logic [DW-1:0] cur_a = '0;
    logic [DW-1:0] cur_b = '0;
    logic [DW-1:0] cur_c = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit three;
        int a;
        int b;
        int c;
        int exp_data;
        int exp_done;
    } vec_t;

    vec_t vecs[6];

    poly_add_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .three_op (three_op),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .a_data   (a_data),
        .b_data   (b_data),
        .c_data   (c_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Operand RAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= cur_a;
            b_data <= cur_b;
            c_data <= cur_c;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},   32'(rd_en),   0);
        check({tag, "_wr_en"},   32'(wr_en),   0);
        check({tag, "_busy"},    32'(busy),    0);
        check({tag, "_done"},    32'(done),    0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
    endtask

    task automatic run_poly(input vec_t v, input int stall_at, input bit poke, input int abort_at);
        int            exp_addr;
        int            done_cnt;
        int            done_cyc;
        int            stall_left;
        int            budget;
        int            extra;
        logic [DW-1:0] held_d;
        cur_a    = DW'(v.a);
        cur_b    = DW'(v.b);
        cur_c    = DW'(v.c);
        three_op = v.three;
        held_d   = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (poke) three_op = ~v.three;
        exp_addr   = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        stall_left = (stall_at >= 0) ? 5 : 0;
        extra      = stall_left;
        budget     = v.exp_done + extra + 4;
        for (int cnt = 1; cnt <= budget; cnt++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (poke && (cnt == 10 || cnt == v.exp_done - 1)) start = 1'b1;
            if (cnt == 1) check("busy_after_start", 32'(busy), 1);
            if (abort_at >= 0 && wr_en && wr_addr == AW'(abort_at)) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(done), 0);
                    check("abort_no_wr", 32'(wr_en), 0);
                end
                rst_n    = 1'b1;
                wr_ready = 1'b1;
                return;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cnt;
                check("busy_at_done", 32'(busy), 0);
            end
            if (wr_en) begin
                if (stall_at >= 0 && wr_addr == AW'(stall_at) && stall_left > 0) begin
                    if (stall_left == 5) held_d = wr_data;
                    else check("stall_data_held", 32'(wr_data), 32'(held_d));
                    check("stall_no_rd", 32'(rd_en), 0);
                    stall_left--;
                    wr_ready = 1'b0;
                end else begin
                    wr_ready = 1'b1;
                    check("wr_addr", 32'(wr_addr), 32'(exp_addr));
                    check("wr_data", 32'(wr_data), 32'(v.exp_data));
                    exp_addr++;
                end
            end else begin
                wr_ready = 1'b1;
            end
        end
        start = 1'b0;
        check("write_count", 32'(exp_addr), N);
        check("done_pulses", 32'(done_cnt), 1);
        check("done_cycle", 32'(done_cyc), 32'(v.exp_done + extra));
        check("busy_after_run", 32'(busy), 0);
        check("rd_after_run", 32'(rd_en), 0);
        if (stall_at >= 0) check("stall_cycles_used", 32'(stall_left), 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 3000, 500,  0,    171,  3*N+1};
        vecs[1] = '{1'b1, 3328, 3328, 3328, 3326, 4*N+1};
        vecs[2] = '{1'b1, 0,    0,    3328, 3328, 4*N+1};
        vecs[3] = '{1'b1, 1664, 1665, 0,    0,    4*N+1};
        vecs[4] = '{1'b0, 1664, 1665, 0,    0,    3*N+1};
        vecs[5] = '{1'b0, 3328, 0,    0,    3328, 3*N+1};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle_outputs("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle");

        for (int i = 0; i < 6; i++) run_poly(vecs[i], -1, 1'b0, -1);

        run_poly(vecs[0], 17, 1'b0, -1);
        run_poly(vecs[0], -1, 1'b1, -1);
        run_poly(vecs[3], -1, 1'b0, -1);
        run_poly(vecs[1], -1, 1'b0, 100);
        run_poly(vecs[0], -1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
